load_sequencer: RTL and testbench

- Sequences load instructions between the execute stage and the data-memory port.
- Accepts one load request, issues a word-aligned read, and waits for the memory acknowledge.
- Extracts the addressed byte or halfword lane and sign- or zero-extends it to DATA_WIDTH.
- Sits between the ALU address path and the register-file writeback mux. Misaligned accesses and unsupported funct3 codes are flagged without touching memory.

---
 rtl/load_sequencer.sv | 150 +++++++++++++++
 tb/tb_load_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_sequencer.sv
// Load sequencer: issues one word-aligned memory read per load and
// returns the byte/half/word lane, sign- or zero-extended.
// Ports: clk_i, rst_i (sync, active-high); req_valid_i/req_ready_o,
//   req_addr_i, req_funct3_i (load request); mem_req_o, mem_addr_o,
//   mem_ack_i, mem_rdata_i (memory read); rsp_valid_o, rsp_data_o,
//   rsp_err_o (one-cycle response pulse).
module load_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]            req_funct3_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [1:0]            r_addr_lo, w_addr_lo_nxt;
  logic [2:0]            r_funct3, w_funct3_nxt;

  logic                  w_bad;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ext;

  // Illegal funct3 or misaligned address, judged on the live request
  always_comb begin
    w_bad = 1'b1;
    unique case (req_funct3_i)
      3'b000, 3'b100: w_bad = 1'b0;
      3'b001, 3'b101: w_bad = req_addr_i[0];
      3'b010:         w_bad = (req_addr_i[1:0] != 2'b00);
      default:        w_bad = 1'b1;
    endcase
  end

  // Lane select uses the captured offset, not the live request
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    unique case (r_addr_lo)
      2'd0: w_byte = mem_rdata_i[7:0];
      2'd1: w_byte = mem_rdata_i[15:8];
      2'd2: w_byte = mem_rdata_i[23:16];
      2'd3: w_byte = mem_rdata_i[31:24];
    endcase
    w_half = r_addr_lo[1] ? mem_rdata_i[31:16]
                          : mem_rdata_i[15:0];
  end

  always_comb begin
    w_ext = mem_rdata_i;
    unique case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = 1'b0;
    w_addr_lo_nxt   = r_addr_lo;
    w_funct3_nxt    = r_funct3;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_addr_lo_nxt = req_addr_i[1:0];
          w_funct3_nxt  = req_funct3_i;
          if (w_bad) begin
            w_state_nxt     = S_ERR;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
          end else begin
            w_state_nxt    = S_WAIT;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          w_state_nxt     = S_RESP;
          w_mem_req_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_ext;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      S_ERR:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_funct3    <= 3'b000;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_addr_lo   <= w_addr_lo_nxt;
      r_funct3    <= w_funct3_nxt;
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: inputs driven and outputs
// checked on the falling clock edge.
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        rdy;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_sequencer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (rdy),
    .req_addr_i   (req_addr),
    .req_funct3_i (req_funct3),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load: k = edges from accept to the edge that samples ack
  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] rd,
                         input int k,
                         input logic [31:0] exp_data,
                         input logic exp_err);
    int hi;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    @(negedge clk);
    chk({tag, " ready"}, 32'(rdy), 32'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_err) begin
      chk({tag, " err_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " err_flag"}, 32'(rsp_err), 32'd1);
      chk({tag, " err_data"}, rsp_data, 32'd0);
      chk({tag, " err_memreq"}, 32'(mem_req), 32'd0);
      chk({tag, " err_ready"}, 32'(rdy), 32'd0);
    end else begin
      hi = 0;
      for (int c = 1; c <= k; c++) begin
        if (mem_req) hi++;
        chk({tag, " maddr"}, mem_addr, waddr);
        chk({tag, " busy"}, 32'(rdy), 32'd0);
        chk({tag, " no_rsp"}, 32'(rsp_valid), 32'd0);
        if (c == k) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk({tag, " req_cycles"}, 32'(hi), 32'(k));
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, " rsp_data"}, rsp_data, exp_data);
      chk({tag, " memreq_off"}, 32'(mem_req), 32'd0);
      chk({tag, " rsp_busy"}, 32'(rdy), 32'd0);
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b000;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(rdy), 32'd1);
    chk("rst memreq", 32'(mem_req), 32'd0);
    chk("rst maddr", mem_addr, 32'd0);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst data", rsp_data, 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    do_load("LB", 3'b000, 32'h0000_0103, 32'h80FF_1234,
            1, 32'hFFFF_FF80, 1'b0);
    do_load("LBU", 3'b100, 32'h0000_0103, 32'h80FF_1234,
            1, 32'h0000_0080, 1'b0);
    do_load("LB1", 3'b000, 32'h0000_0101, 32'h80FF_1234,
            2, 32'h0000_0012, 1'b0);
    do_load("LH", 3'b001, 32'h0000_0002, 32'h8001_7FFF,
            1, 32'hFFFF_8001, 1'b0);
    do_load("LHU", 3'b101, 32'h0000_0002, 32'h8001_7FFF,
            1, 32'h0000_8001, 1'b0);
    do_load("LH0", 3'b001, 32'h0000_0000, 32'h8001_7FFF,
            1, 32'h0000_7FFF, 1'b0);
    do_load("LW", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF,
            4, 32'hDEAD_BEEF, 1'b0);
    do_load("LWmis", 3'b010, 32'h0000_0006, 32'h1111_1111,
            1, 32'h0, 1'b1);
    do_load("LHmis", 3'b001, 32'h0000_0005, 32'h1111_1111,
            1, 32'h0, 1'b1);
    do_load("F011", 3'b011, 32'h0000_0000, 32'h1111_1111,
            1, 32'h0, 1'b1);

    // Reset while waiting for ack, then a stray ack
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0040;
    req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrst memreq_on", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst memreq", 32'(mem_req), 32'd0);
    chk("wrst maddr", mem_addr, 32'd0);
    chk("wrst ready", 32'(rdy), 32'd1);
    chk("wrst valid", 32'(rsp_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack valid", 32'(rsp_valid), 32'd0);
    chk("late_ack ready", 32'(rdy), 32'd1);
    chk("late_ack memreq", 32'(mem_req), 32'd0);
    chk("late_ack data", rsp_data, 32'd0);

    // Reset and request together: request dropped
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0080;
    req_funct3 = 3'b010;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    chk("rstreq ready", 32'(rdy), 32'd1);
    chk("rstreq memreq", 32'(mem_req), 32'd0);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0020;
    req_funct3 = 3'b010;
    @(negedge clk);
    chk("b2b memreq1", 32'(mem_req), 32'd1);
    chk("b2b maddr1", mem_addr, 32'h0000_0020);
    chk("b2b busy1", 32'(rdy), 32'd0);
    req_addr   = 32'h0000_0025;
    req_funct3 = 3'b100;
    mem_ack    = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b rsp1", 32'(rsp_valid), 32'd1);
    chk("b2b data1", rsp_data, 32'hCAFE_F00D);
    chk("b2b busy2", 32'(rdy), 32'd0);
    chk("b2b memreq_off", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("b2b idle", 32'(rdy), 32'd1);
    chk("b2b rsp_end", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b memreq2", 32'(mem_req), 32'd1);
    chk("b2b maddr2", mem_addr, 32'h0000_0024);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_A678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b rsp2", 32'(rsp_valid), 32'd1);
    chk("b2b data2", rsp_data, 32'h0000_00A6);
    chk("b2b err2", 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk("b2b end", 32'(rdy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
